mii_frame_generator: RTL and testbench
======================================

MII_FRAME_GENERATOR -- requirements
Module: mii_frame_generator

Interface
REQ-001 Parameter LEN_DATA_BLOCK, default 64: width of o_tx_data, eight lanes of 8 bits.
REQ-002 Parameter LEN_CTRL_BLOCK, default 8: width of o_tx_ctrl, one bit per lane; 1 means the lane holds a control character.
REQ-003 Parameter NB_LEN, default 16: width of i_data_blocks and o_frame_count.
REQ-004 i_clock  in  1  clock; all logic on its rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_enable  in  1  clock enable; when low, all state and outputs hold.
REQ-007 i_data_blocks  in  NB_LEN  data blocks per frame; 0 is treated as 1.
REQ-008 i_idle_blocks  in  8  idle blocks between frames; 0 is legal.
REQ-009 o_tx_data  out  LEN_DATA_BLOCK  registered block data; lane 0 = bits [63:56].
REQ-010 o_tx_ctrl  out  LEN_CTRL_BLOCK  registered control flags; bit 7 = lane 0.
REQ-011 o_sof  out  1  high for exactly the cycle in which the START block is output.
REQ-012 o_frame_count  out  NB_LEN  count of TERM blocks emitted; wraps modulo 2^NB_LEN.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA and TERM; each enabled edge registers one output block for the new state.
REQ-014 IDLE block SHALL be data 0x0707070707070707, ctrl 0xFF.
REQ-015 START block SHALL be data 0xFB555555555555D5, ctrl 0x80.
REQ-016 DATA block SHALL have ctrl 0x00, with the payload defined in REQ-024/REQ-025.
REQ-017 TERM block SHALL be data 0xFD07070707070707, ctrl 0xFF.
REQ-018 From IDLE, the FSM SHALL emit i_idle_blocks IDLE blocks and then START; with i_idle_blocks = 0 it SHALL go directly to START, including from TERM.
REQ-019 i_data_blocks and i_idle_blocks SHALL be latched on the edge that emits START; changes mid-frame take effect from the next frame.
REQ-020 After START, the FSM SHALL emit exactly M DATA blocks, where M is the latched i_data_blocks (or 1 if it is 0), then one TERM.
REQ-021 The frame period SHALL be N + M + 2 blocks, where N is the idle count; there are no gaps or stalls while i_enable is high.
REQ-022 Per-frame data index k SHALL be 0..M-1 and SHALL restart at 0 on each START.
REQ-023 o_frame_count SHALL increment on the edge that emits TERM.

Reset
REQ-026 While i_reset is high: state = IDLE, idle counter = 0, o_tx_data/o_tx_ctrl = IDLE block, o_sof = 0, o_frame_count = 0, data index = 0, PRBS state = seed.
REQ-027 i_reset SHALL take priority over i_enable.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without emitting TERM and without incrementing o_frame_count.
REQ-029 After reset release, the first enabled edge SHALL begin counting idle blocks with the current i_idle_blocks.

Configuration
REQ-024 Without PRBS_PAYLOAD_EN: every byte of DATA block k SHALL be k[7:0], so k wraps after 256.
REQ-025 With PRBS_PAYLOAD_EN defined: the DATA payload SHALL be the next 64 bits of PRBS31 (x^31+x^28+1, seed 31'h7FFFFFFF, MSB first).
- The PRBS SHALL advance only on DATA edges.
- The PRBS SHALL continue across frames and reset only on i_reset.
- The PRBS logic SHALL not exist in the netlist when the macro is undefined.

Verification
REQ-030 Reset, then i_idle_blocks=2, i_data_blocks=3, i_enable=1 -> outputs in order:
- IDLE, IDLE
- START with o_sof=1
- data 0x00..00, 0x0101..01, 0x0202..02
- TERM, with o_frame_count=1
- IDLE, IDLE, START again.
REQ-031 i_idle_blocks=0, i_data_blocks=1 -> repeating START, DATA(0x00..00), TERM with no IDLE blocks; o_frame_count +1 every 3 cycles.
REQ-032 i_data_blocks=0 -> behaves as 1: START, one DATA, TERM.
REQ-033 i_enable low for 5 cycles during DATA k=1 -> outputs hold 0x0101..01; the sequence then resumes with k=2 and no block is lost.
REQ-034 i_reset pulsed during DATA of frame 3 -> next cycle IDLE with o_frame_count=0; the next frame restarts at k=0.
REQ-035 i_data_blocks changed from 3 to 5 during DATA -> the current frame keeps 3 DATA blocks and the next frame has 5.

Source files
------------

// File: rtl/mii_frame_generator.sv
// MII/XGMII test-frame generator: IDLE gap, START, M DATA blocks, TERM, repeating.
// Define PRBS_PAYLOAD_EN to replace the index-byte payload with a continuous PRBS31 stream.
module mii_frame_generator #(
    parameter int LEN_DATA_BLOCK = 64,
    parameter int LEN_CTRL_BLOCK = 8,
    parameter int NB_LEN         = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [NB_LEN-1:0]         i_data_blocks,
    input  logic [7:0]                i_idle_blocks,
    output logic [LEN_DATA_BLOCK-1:0] o_tx_data,
    output logic [LEN_CTRL_BLOCK-1:0] o_tx_ctrl,
    output logic                      o_sof,
    output logic [NB_LEN-1:0]         o_frame_count
);

    localparam logic [LEN_DATA_BLOCK-1:0] IDLE_DATA  = 64'h0707070707070707;
    localparam logic [LEN_DATA_BLOCK-1:0] START_DATA = 64'hFB555555555555D5;
    localparam logic [LEN_DATA_BLOCK-1:0] TERM_DATA  = 64'hFD07070707070707;
    localparam logic [LEN_CTRL_BLOCK-1:0] CTRL_ALL   = 8'hFF;
    localparam logic [LEN_CTRL_BLOCK-1:0] CTRL_START = 8'h80;
    localparam logic [LEN_CTRL_BLOCK-1:0] CTRL_NONE  = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_TERM  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [7:0]                idle_cnt_q, idle_cnt_d;
    logic [7:0]                idle_len_q, idle_len_d;
    logic [NB_LEN-1:0]         data_len_q, data_len_d;
    logic [NB_LEN-1:0]         data_idx_q, data_idx_d;
    logic                      first_gap_q, first_gap_d;
    logic [NB_LEN-1:0]         frame_cnt_d;
    logic [LEN_DATA_BLOCK-1:0] tx_data_d;
    logic [LEN_CTRL_BLOCK-1:0] tx_ctrl_d;
    logic                      sof_d;
    logic [7:0]                idle_target;
    logic [LEN_DATA_BLOCK-1:0] payload;

`ifdef PRBS_PAYLOAD_EN
    logic [30:0]               prbs_q, prbs_d, prbs_next;
    logic [LEN_DATA_BLOCK-1:0] prbs_word;

    // Unroll 64 steps of x^31+x^28+1; the first generated bit lands in the MSB.
    always_comb begin
        logic [30:0] s;
        logic        fb;
        s         = prbs_q;
        prbs_word = '0;
        for (int i = LEN_DATA_BLOCK - 1; i >= 0; i--) begin
            fb           = s[30] ^ s[27];
            s            = {s[29:0], fb};
            prbs_word[i] = fb;
        end
        prbs_next = s;
    end

    assign payload = prbs_word;
    assign prbs_d  = (state_d == S_DATA) ? prbs_next : prbs_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            prbs_q <= 31'h7FFFFFFF;
        end else if (i_enable) begin
            prbs_q <= prbs_d;
        end
    end
`else
    assign payload = {8{data_idx_q[7:0]}};
`endif

    // Right after reset no frame has latched a gap length yet, so the live input is used.
    assign idle_target = first_gap_q ? i_idle_blocks : idle_len_q;

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        idle_len_d  = idle_len_q;
        data_len_d  = data_len_q;
        data_idx_d  = data_idx_q;
        first_gap_d = first_gap_q;
        frame_cnt_d = o_frame_count;
        tx_data_d   = IDLE_DATA;
        tx_ctrl_d   = CTRL_ALL;
        sof_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (idle_cnt_q >= idle_target) begin
                    state_d = S_START;
                end else begin
                    state_d    = S_IDLE;
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            S_START: state_d = S_DATA;
            S_DATA:  state_d = (data_idx_q >= data_len_q) ? S_TERM : S_DATA;
            S_TERM: begin
                if (idle_len_q == 8'd0) begin
                    state_d = S_START;
                end else begin
                    state_d    = S_IDLE;
                    idle_cnt_d = 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The registered block always describes the state being entered.
        case (state_d)
            S_START: begin
                tx_data_d   = START_DATA;
                tx_ctrl_d   = CTRL_START;
                sof_d       = 1'b1;
                data_len_d  = (i_data_blocks == '0) ? NB_LEN'(1) : i_data_blocks;
                idle_len_d  = i_idle_blocks;
                data_idx_d  = '0;
                idle_cnt_d  = 8'd0;
                first_gap_d = 1'b0;
            end
            S_DATA: begin
                tx_data_d  = payload;
                tx_ctrl_d  = CTRL_NONE;
                data_idx_d = data_idx_q + NB_LEN'(1);
            end
            S_TERM: begin
                tx_data_d   = TERM_DATA;
                tx_ctrl_d   = CTRL_ALL;
                frame_cnt_d = o_frame_count + NB_LEN'(1);
            end
            default: begin
                tx_data_d = IDLE_DATA;
                tx_ctrl_d = CTRL_ALL;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= S_IDLE;
            idle_cnt_q    <= 8'd0;
            idle_len_q    <= 8'd0;
            data_len_q    <= NB_LEN'(1);
            data_idx_q    <= '0;
            first_gap_q   <= 1'b1;
            o_frame_count <= '0;
            o_tx_data     <= IDLE_DATA;
            o_tx_ctrl     <= CTRL_ALL;
            o_sof         <= 1'b0;
        end else if (i_enable) begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            idle_len_q    <= idle_len_d;
            data_len_q    <= data_len_d;
            data_idx_q    <= data_idx_d;
            first_gap_q   <= first_gap_d;
            o_frame_count <= frame_cnt_d;
            o_tx_data     <= tx_data_d;
            o_tx_ctrl     <= tx_ctrl_d;
            o_sof         <= sof_d;
        end
    end

endmodule

// File: tb/tb_mii_frame_generator.sv
// Self-checking bench for mii_frame_generator (default build, index-byte payload).
module tb_mii_frame_generator;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [15:0] i_data_blocks;
    logic [7:0]  i_idle_blocks;
    logic [63:0] o_tx_data;
    logic [7:0]  o_tx_ctrl;
    logic        o_sof;
    logic [15:0] o_frame_count;

    always #5 i_clock = ~i_clock;

    mii_frame_generator dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_data_blocks (i_data_blocks),
        .i_idle_blocks (i_idle_blocks),
        .o_tx_data     (o_tx_data),
        .o_tx_ctrl     (o_tx_ctrl),
        .o_sof         (o_sof),
        .o_frame_count (o_frame_count)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic        sof;
        logic [15:0] cnt;
    } blk_t;

    typedef struct {
        logic  en;
        blk_t  exp;
        string name;
    } vec_t;

    blk_t sb_q[$];
    vec_t vecs[10];
    int   errors = 0;
    int   checks = 0;

    function automatic blk_t mk_idle(logic [15:0] c);
        return '{64'h0707070707070707, 8'hFF, 1'b0, c};
    endfunction

    function automatic blk_t mk_start(logic [15:0] c);
        return '{64'hFB555555555555D5, 8'h80, 1'b1, c};
    endfunction

    function automatic blk_t mk_data(logic [7:0] k, logic [15:0] c);
        return '{{8{k}}, 8'h00, 1'b0, c};
    endfunction

    function automatic blk_t mk_term(logic [15:0] c);
        return '{64'hFD07070707070707, 8'hFF, 1'b0, c};
    endfunction

    task automatic check(input string name, input logic [88:0] act, input logic [88:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got data=%h ctrl=%h sof=%b cnt=%0d, expected data=%h ctrl=%h sof=%b cnt=%0d",
                     name, act[88:25], act[24:17], act[16], act[15:0],
                     exp[88:25], exp[24:17], exp[16], exp[15:0]);
        end
    endtask

    // One clock: sample outputs 1 ns after the edge and compare against the scoreboard head.
    task automatic step(input string name);
        blk_t e;
        @(posedge i_clock);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, no expected block", name);
        end else begin
            e = sb_q.pop_front();
            check(name, {o_tx_data, o_tx_ctrl, o_sof, o_frame_count},
                  {e.data, e.ctrl, e.sof, e.cnt});
        end
    endtask

    task automatic expect_step(input blk_t b, input string name);
        sb_q.push_back(b);
        step(name);
    endtask

    initial begin
        vecs[0] = '{1'b1, mk_idle(16'd0),     "t030_idle0"};
        vecs[1] = '{1'b1, mk_idle(16'd0),     "t030_idle1"};
        vecs[2] = '{1'b1, mk_start(16'd0),    "t030_start"};
        vecs[3] = '{1'b1, mk_data(8'd0, 16'd0), "t030_d0"};
        vecs[4] = '{1'b1, mk_data(8'd1, 16'd0), "t030_d1"};
        vecs[5] = '{1'b1, mk_data(8'd2, 16'd0), "t030_d2"};
        vecs[6] = '{1'b1, mk_term(16'd1),     "t030_term"};
        vecs[7] = '{1'b1, mk_idle(16'd1),     "t030_idle2"};
        vecs[8] = '{1'b1, mk_idle(16'd1),     "t030_idle3"};
        vecs[9] = '{1'b1, mk_start(16'd1),    "t030_start2"};

        // Reset must win even with the enable low.
        i_reset       = 1'b1;
        i_enable      = 1'b0;
        i_idle_blocks = 8'd2;
        i_data_blocks = 16'd3;
        expect_step(mk_idle(16'd0), "reset_vs_enable_low");
        i_enable = 1'b1;
        expect_step(mk_idle(16'd0), "reset_hold");
        i_reset = 1'b0;

        // Basic frame: 2 idles, START, 3 DATA, TERM, then the next gap.
        foreach (vecs[i]) begin
            i_enable = vecs[i].en;
            expect_step(vecs[i].exp, vecs[i].name);
        end

        // Frame 2: length change mid-frame plus a 5-cycle enable stall at k=1.
        expect_step(mk_data(8'd0, 16'd1), "f2_d0");
        i_data_blocks = 16'd5;
        expect_step(mk_data(8'd1, 16'd1), "f2_d1");
        i_enable = 1'b0;
        for (int i = 0; i < 5; i++) expect_step(mk_data(8'd1, 16'd1), "stall_hold");
        i_enable = 1'b1;
        expect_step(mk_data(8'd2, 16'd1), "f2_d2_resume");
        expect_step(mk_term(16'd2),       "f2_term_keeps_3");
        expect_step(mk_idle(16'd2),       "f3_idle0");
        expect_step(mk_idle(16'd2),       "f3_idle1");
        expect_step(mk_start(16'd2),      "f3_start");
        for (int k = 0; k < 3; k++) expect_step(mk_data(8'(k), 16'd2), "f3_data");

        // Reset in the middle of frame 3's DATA run: no TERM, count cleared.
        i_reset = 1'b1;
        expect_step(mk_idle(16'd0), "midframe_reset");
        i_reset       = 1'b0;
        i_idle_blocks = 8'd0;
        i_data_blocks = 16'd1;

        // Zero idle gap: START, DATA, TERM back to back, restarting at k=0.
        for (int f = 1; f <= 3; f++) begin
            expect_step(mk_start(16'(f - 1)),       "b2b_start");
            expect_step(mk_data(8'd0, 16'(f - 1)),  "b2b_d0");
            expect_step(mk_term(16'(f)),            "b2b_term");
        end

        // Zero data blocks is treated as one.
        i_data_blocks = 16'd0;
        for (int f = 4; f <= 5; f++) begin
            expect_step(mk_start(16'(f - 1)),       "zero_len_start");
            expect_step(mk_data(8'd0, 16'(f - 1)),  "zero_len_d0");
            expect_step(mk_term(16'(f)),            "zero_len_term");
        end

        // Gap of one idle block; new settings latched on the START edge.
        i_idle_blocks = 8'd1;
        i_data_blocks = 16'd2;
        expect_step(mk_start(16'd5),       "gap1_start");
        expect_step(mk_data(8'd0, 16'd5),  "gap1_d0");
        expect_step(mk_data(8'd1, 16'd5),  "gap1_d1");
        expect_step(mk_term(16'd6),        "gap1_term");
        expect_step(mk_idle(16'd6),        "gap1_idle");
        expect_step(mk_start(16'd6),       "gap1_start2");
        expect_step(mk_data(8'd0, 16'd6),  "gap1_next_d0");

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expected blocks left unchecked", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
